// File: rtl/local_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : local_mem_arbiter
// Purpose  : Round-robin arbiter that lets two requesters share one
//            local_mem request/response port.
//            Requester 0 is the Vortex memory port. Requester 1 is the
//            host/loader port.
//            The request stage toward memory is registered. The requester
//            ID travels in the MSB of the memory tag, and responses are
//            steered back combinationally. A per-requester outstanding-read
//            counter throttles reads and drives busy.
// Ports    : clk, reset_n (async active-low)
//            rq_req_*  [1:0]  requester request channels (valid/ready)
//            rq_rsp_*  [1:0]  requester response channels (valid/ready)
//            mem_req_*        registered request toward local_mem
//            mem_rsp_*        response from local_mem
//            busy             request held or any read outstanding
//            rsp_err          sticky: response arrived with nothing outstanding
// Revision : 1.0  initial release
// ============================================================================
module local_mem_arbiter #(
   parameter int ADDR_W   = 26,
   parameter int DATA_W   = 512,
   parameter int BYTEEN_W = DATA_W / 8,
   parameter int TAG_W    = 8,
   parameter int MAX_OUTS = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [1:0]               rq_req_valid,
   input  logic [1:0]               rq_req_rw,
   input  logic [1:0][BYTEEN_W-1:0] rq_req_byteen,
   input  logic [1:0][ADDR_W-1:0]   rq_req_addr,
   input  logic [1:0][DATA_W-1:0]   rq_req_data,
   input  logic [1:0][TAG_W-1:0]    rq_req_tag,
   output logic [1:0]               rq_req_ready,
   output logic [1:0]               rq_rsp_valid,
   output logic [1:0][DATA_W-1:0]   rq_rsp_data,
   output logic [1:0][TAG_W-1:0]    rq_rsp_tag,
   input  logic [1:0]               rq_rsp_ready,
   output logic                     mem_req_valid,
   output logic                     mem_req_rw,
   output logic [BYTEEN_W-1:0]      mem_req_byteen,
   output logic [ADDR_W-1:0]        mem_req_addr,
   output logic [DATA_W-1:0]        mem_req_data,
   output logic [TAG_W:0]           mem_req_tag,
   input  logic                     mem_req_ready,
   input  logic                     mem_rsp_valid,
   input  logic [DATA_W-1:0]        mem_rsp_data,
   input  logic [TAG_W:0]           mem_rsp_tag,
   output logic                     mem_rsp_ready,
   output logic                     busy,
   output logic                     rsp_err
);

   localparam int CNT_W = $clog2(MAX_OUTS + 1);
   localparam logic [CNT_W-1:0] c_max_outs = CNT_W'(MAX_OUTS);

   logic                r_mem_req_valid;
   logic                r_mem_req_rw;
   logic [BYTEEN_W-1:0] r_mem_req_byteen;
   logic [ADDR_W-1:0]   r_mem_req_addr;
   logic [DATA_W-1:0]   r_mem_req_data;
   logic [TAG_W:0]      r_mem_req_tag;
   logic                r_last;      // requester granted most recently
   logic                r_rsp_err;

   logic                w_load;
   logic [1:0]          w_elig;
   logic [1:0]          w_grant;
   logic                w_sel;
   logic                w_rsp_id;
   logic                w_rsp_fire;
   logic [1:0]          w_cnt_nz;
   logic [1:0]          w_underflow;

   // The output slot can take a new request when it is empty or draining this
   // cycle, which sustains one request per cycle.
   assign w_load = !r_mem_req_valid || mem_req_ready;

   // r_last resets to 1 so requester 0 wins the first contended cycle.
   assign w_grant[0] = w_load && w_elig[0] && (!w_elig[1] || r_last);
   assign w_grant[1] = w_load && w_elig[1] && (!w_elig[0] || !r_last);
   assign w_sel      = w_grant[1];
   assign rq_req_ready = w_grant;

   // Response steering: valid goes only to the owning requester. Data and
   // tag are broadcast to both requesters.
   assign w_rsp_id      = mem_rsp_tag[TAG_W];
   assign rq_rsp_valid  = w_rsp_id ? {mem_rsp_valid, 1'b0} : {1'b0, mem_rsp_valid};
   assign mem_rsp_ready = rq_rsp_ready[w_rsp_id];
   assign w_rsp_fire    = mem_rsp_valid && mem_rsp_ready;
   assign rq_rsp_data   = {2{mem_rsp_data}};
   assign rq_rsp_tag    = {2{mem_rsp_tag[TAG_W-1:0]}};

   for (genvar i = 0; i < 2; i++) begin : g_req
      logic [CNT_W-1:0] r_cnt;
      logic             w_inc;
      logic             w_dec;
      logic             w_id_match;

      assign w_id_match = (i == 0) ? !w_rsp_id : w_rsp_id;
      // Only reads are throttled; writes produce no response.
      assign w_elig[i]  = rq_req_valid[i] && !(!rq_req_rw[i] && (r_cnt == c_max_outs));
      assign w_inc      = w_grant[i] && !rq_req_rw[i];
      assign w_dec      = w_rsp_fire && w_id_match;
      assign w_cnt_nz[i]    = (r_cnt != '0);
      assign w_underflow[i] = w_dec && !w_inc && (r_cnt == '0);

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            r_cnt <= '0;
         end else if (w_inc && !w_dec) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end else if (w_dec && !w_inc && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mem_req_valid  <= 1'b0;
         r_mem_req_rw     <= 1'b0;
         r_mem_req_byteen <= '0;
         r_mem_req_addr   <= '0;
         r_mem_req_data   <= '0;
         r_mem_req_tag    <= '0;
         r_last           <= 1'b1;
      end else if (|w_grant) begin
         r_mem_req_valid  <= 1'b1;
         r_mem_req_rw     <= rq_req_rw[w_sel];
         r_mem_req_byteen <= rq_req_byteen[w_sel];
         r_mem_req_addr   <= rq_req_addr[w_sel];
         r_mem_req_data   <= rq_req_data[w_sel];
         r_mem_req_tag    <= {w_sel, rq_req_tag[w_sel]};
         r_last           <= w_sel;
      end else if (mem_req_ready) begin
         r_mem_req_valid  <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rsp_err <= 1'b0;
      end else if (|w_underflow) begin
         r_rsp_err <= 1'b1;
      end
   end

   assign mem_req_valid  = r_mem_req_valid;
   assign mem_req_rw     = r_mem_req_rw;
   assign mem_req_byteen = r_mem_req_byteen;
   assign mem_req_addr   = r_mem_req_addr;
   assign mem_req_data   = r_mem_req_data;
   assign mem_req_tag    = r_mem_req_tag;
   assign busy           = r_mem_req_valid || (|w_cnt_nz);
   assign rsp_err        = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_local_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_local_mem_arbiter
// Purpose  : Directed self-checking bench for local_mem_arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_local_mem_arbiter;

   localparam int ADDR_W   = 26;
   localparam int DATA_W   = 64;
   localparam int BYTEEN_W = DATA_W / 8;
   localparam int TAG_W    = 8;
   localparam int MAX_OUTS = 8;

   logic                     clk;
   logic                     reset_n;
   logic [1:0]               rq_req_valid;
   logic [1:0]               rq_req_rw;
   logic [1:0][BYTEEN_W-1:0] rq_req_byteen;
   logic [1:0][ADDR_W-1:0]   rq_req_addr;
   logic [1:0][DATA_W-1:0]   rq_req_data;
   logic [1:0][TAG_W-1:0]    rq_req_tag;
   logic [1:0]               rq_req_ready;
   logic [1:0]               rq_rsp_valid;
   logic [1:0][DATA_W-1:0]   rq_rsp_data;
   logic [1:0][TAG_W-1:0]    rq_rsp_tag;
   logic [1:0]               rq_rsp_ready;
   logic                     mem_req_valid;
   logic                     mem_req_rw;
   logic [BYTEEN_W-1:0]      mem_req_byteen;
   logic [ADDR_W-1:0]        mem_req_addr;
   logic [DATA_W-1:0]        mem_req_data;
   logic [TAG_W:0]           mem_req_tag;
   logic                     mem_req_ready;
   logic                     mem_rsp_valid;
   logic [DATA_W-1:0]        mem_rsp_data;
   logic [TAG_W:0]           mem_rsp_tag;
   logic                     mem_rsp_ready;
   logic                     busy;
   logic                     rsp_err;

   int r_checks = 0;
   int r_fails  = 0;

   local_mem_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BYTEEN_W(BYTEEN_W),
      .TAG_W(TAG_W), .MAX_OUTS(MAX_OUTS)
   ) u_dut (
      .clk(clk), .reset_n(reset_n),
      .rq_req_valid(rq_req_valid), .rq_req_rw(rq_req_rw),
      .rq_req_byteen(rq_req_byteen), .rq_req_addr(rq_req_addr),
      .rq_req_data(rq_req_data), .rq_req_tag(rq_req_tag),
      .rq_req_ready(rq_req_ready),
      .rq_rsp_valid(rq_rsp_valid), .rq_rsp_data(rq_rsp_data),
      .rq_rsp_tag(rq_rsp_tag), .rq_rsp_ready(rq_rsp_ready),
      .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
      .mem_req_byteen(mem_req_byteen), .mem_req_addr(mem_req_addr),
      .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
      .mem_req_ready(mem_req_ready),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
      .mem_rsp_tag(mem_rsp_tag), .mem_rsp_ready(mem_rsp_ready),
      .busy(busy), .rsp_err(rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      r_checks++;
      if (obs !== exp) begin
         r_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle_inputs();
      rq_req_valid  = '0;
      rq_req_rw     = '0;
      rq_req_byteen = '0;
      rq_req_addr   = '0;
      rq_req_data   = '0;
      rq_req_tag    = '0;
      rq_rsp_ready  = '0;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      mem_rsp_tag   = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset_n = 1'b0;
      step();
      step();
      reset_n = 1'b1;
      settle();
   endtask

   initial begin
      reset_n = 1'b0;
      idle_inputs();
      #2;
      // ---------------- reset state ----------------
      check("rst_mem_req_valid", 64'(mem_req_valid), 64'h0);
      check("rst_mem_req_addr",  64'(mem_req_addr),  64'h0);
      check("rst_mem_req_tag",   64'(mem_req_tag),   64'h0);
      check("rst_busy",          64'(busy),          64'h0);
      check("rst_rsp_err",       64'(rsp_err),       64'h0);
      check("rst_rq_req_ready",  64'(rq_req_ready),  64'h0);
      check("rst_rq_rsp_valid",  64'(rq_rsp_valid),  64'h0);
      check("rst_mem_rsp_ready", 64'(mem_rsp_ready), 64'h0);
      do_reset();

      // ---------------- single read from req0 ----------------
      mem_req_ready   = 1'b1;
      rq_req_valid[0] = 1'b1;
      rq_req_rw[0]    = 1'b0;
      rq_req_addr[0]  = 26'h10;
      rq_req_tag[0]   = 8'h05;
      rq_req_byteen[0] = 8'hFF;
      settle();
      check("t1_ready", 64'(rq_req_ready), 64'h1);
      step();
      rq_req_valid[0] = 1'b0;
      check("t1_mem_valid", 64'(mem_req_valid), 64'h1);
      check("t1_mem_addr",  64'(mem_req_addr),  64'h10);
      check("t1_mem_tag",   64'(mem_req_tag),   64'h005);
      check("t1_mem_rw",    64'(mem_req_rw),    64'h0);
      check("t1_busy",      64'(busy),          64'h1);
      step();
      check("t1_mem_valid_drain", 64'(mem_req_valid), 64'h0);
      check("t1_busy_outstanding", 64'(busy), 64'h1);
      mem_rsp_valid = 1'b1;
      mem_rsp_tag   = 9'h005;
      mem_rsp_data  = 64'hDEAD_BEEF_0123_4567;
      rq_rsp_ready  = 2'b01;
      settle();
      check("t1_rsp_valid",  64'(rq_rsp_valid),   64'h1);
      check("t1_rsp_tag0",   64'(rq_rsp_tag[0]),  64'h05);
      check("t1_rsp_data0",  64'(rq_rsp_data[0]), 64'hDEAD_BEEF_0123_4567);
      check("t1_rsp_data1",  64'(rq_rsp_data[1]), 64'hDEAD_BEEF_0123_4567);
      check("t1_mem_rsp_ready", 64'(mem_rsp_ready), 64'h1);
      step();
      mem_rsp_valid = 1'b0;
      settle();
      check("t1_busy_done", 64'(busy),    64'h0);
      check("t1_no_err",    64'(rsp_err), 64'h0);
      do_reset();

      // ---------------- alternation under contention ----------------
      mem_req_ready  = 1'b1;
      rq_req_valid   = 2'b11;
      rq_req_rw      = 2'b00;
      rq_req_tag[0]  = 8'h10;
      rq_req_tag[1]  = 8'h20;
      rq_req_addr[0] = 26'h100;
      rq_req_addr[1] = 26'h200;
      for (int k = 0; k < 4; k++) begin
         settle();
         check("t2_grant", 64'(rq_req_ready), (k % 2 == 0) ? 64'h1 : 64'h2);
         step();
         check("t2_tag", 64'(mem_req_tag), (k % 2 == 0) ? 64'h010 : 64'h120);
         check("t2_addr", 64'(mem_req_addr), (k % 2 == 0) ? 64'h100 : 64'h200);
      end
      do_reset();

      // ---------------- request backpressure ----------------
      mem_req_ready   = 1'b0;
      rq_req_valid[1] = 1'b1;
      rq_req_rw[1]    = 1'b1;
      rq_req_addr[1]  = 26'h3;
      rq_req_tag[1]   = 8'h33;
      rq_req_data[1]  = 64'hA5A5;
      settle();
      check("t3_first_grant", 64'(rq_req_ready), 64'h2);
      step();
      rq_req_addr[1] = 26'h4;
      rq_req_tag[1]  = 8'h34;
      rq_req_data[1] = 64'h5A5A;
      rq_req_valid[0] = 1'b1;
      rq_req_rw[0]    = 1'b0;
      for (int k = 0; k < 3; k++) begin
         settle();
         check("t3_stall_ready", 64'(rq_req_ready), 64'h0);
         check("t3_hold_valid",  64'(mem_req_valid), 64'h1);
         check("t3_hold_addr",   64'(mem_req_addr),  64'h3);
         check("t3_hold_tag",    64'(mem_req_tag),   64'h133);
         check("t3_hold_data",   64'(mem_req_data),  64'hA5A5);
         step();
      end
      rq_req_valid[0] = 1'b0;
      mem_req_ready = 1'b1;
      settle();
      check("t3_same_cycle_grant", 64'(rq_req_ready), 64'h2);
      step();
      rq_req_valid[1] = 1'b0;
      check("t3_next_addr", 64'(mem_req_addr), 64'h4);
      check("t3_next_tag",  64'(mem_req_tag),  64'h134);
      check("t3_next_rw",   64'(mem_req_rw),   64'h1);
      step();
      check("t3_write_not_counted", 64'(busy), 64'h0);
      do_reset();

      // ---------------- read throttle ----------------
      mem_req_ready   = 1'b1;
      rq_req_valid[0] = 1'b1;
      rq_req_rw[0]    = 1'b0;
      for (int k = 0; k < MAX_OUTS; k++) begin
         rq_req_tag[0] = 8'(k);
         settle();
         check("t4_fill_grant", 64'(rq_req_ready), 64'h1);
         step();
      end
      rq_req_valid[1] = 1'b1;
      rq_req_rw[1]    = 1'b0;
      rq_req_tag[1]   = 8'h77;
      settle();
      check("t4_throttled", 64'(rq_req_ready), 64'h2);
      step();
      check("t4_req1_tag", 64'(mem_req_tag), 64'h177);
      rq_req_rw[0] = 1'b1;
      settle();
      check("t4_write_passes", 64'(rq_req_ready), 64'h1);
      step();
      rq_req_rw[0]    = 1'b0;
      rq_req_valid[1] = 1'b0;
      mem_rsp_valid   = 1'b1;
      mem_rsp_tag     = 9'h000;
      rq_rsp_ready    = 2'b01;
      settle();
      check("t4_still_full", 64'(rq_req_ready), 64'h0);
      step();
      mem_rsp_valid = 1'b0;
      settle();
      check("t4_freed", 64'(rq_req_ready), 64'h1);
      do_reset();

      // ---------------- response backpressure ----------------
      mem_req_ready   = 1'b1;
      rq_req_valid[1] = 1'b1;
      rq_req_rw[1]    = 1'b0;
      rq_req_tag[1]   = 8'hAA;
      step();
      rq_req_valid[1] = 1'b0;
      step();
      mem_rsp_valid = 1'b1;
      mem_rsp_tag   = 9'h1AA;
      rq_rsp_ready  = 2'b00;
      settle();
      check("t5_rsp_valid",  64'(rq_rsp_valid),  64'h2);
      check("t5_rsp_tag1",   64'(rq_rsp_tag[1]), 64'hAA);
      check("t5_mem_rsp_ready", 64'(mem_rsp_ready), 64'h0);
      step();
      step();
      check("t5_cnt_held", 64'(busy), 64'h1);
      rq_rsp_ready = 2'b10;
      settle();
      check("t5_mem_rsp_ready_hi", 64'(mem_rsp_ready), 64'h1);
      step();
      mem_rsp_valid = 1'b0;
      rq_rsp_ready  = 2'b00;
      settle();
      check("t5_cnt_dec", 64'(busy), 64'h0);

      // ---------------- spurious response and mid-burst reset ----------------
      mem_rsp_valid = 1'b1;
      mem_rsp_tag   = 9'h0FF;
      rq_rsp_ready  = 2'b01;
      step();
      mem_rsp_valid = 1'b0;
      settle();
      check("t6_err_set", 64'(rsp_err), 64'h1);
      check("t6_busy_sat", 64'(busy), 64'h0);
      step();
      step();
      check("t6_err_sticky", 64'(rsp_err), 64'h1);
      mem_req_ready = 1'b1;
      rq_req_valid  = 2'b11;
      rq_req_rw     = 2'b00;
      step();
      step();
      mem_req_ready = 1'b0;
      step();
      check("t6_burst_busy", 64'(busy), 64'h1);
      #2;
      reset_n = 1'b0;
      #1;
      check("t6_rst_valid", 64'(mem_req_valid), 64'h0);
      check("t6_rst_busy",  64'(busy),          64'h0);
      check("t6_rst_err",   64'(rsp_err),       64'h0);
      idle_inputs();
      step();
      reset_n = 1'b1;
      settle();
      check("t6_post_rst_busy", 64'(busy), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", r_checks, r_fails);
      $finish;
   end

   // Safety net against a stuck simulation.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach the end");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/local_mem_arbiter.md
Name: local_mem_arbiter

Overview:
- Two-requester round-robin arbiter that shares one local_mem request/response port.
- Requester 0 is the Vortex memory port; requester 1 is the host/loader port (program load, result readback).
- Registered request stage toward memory; requester ID carried in the MSB of the memory tag; responses routed back combinationally.
- Per-requester outstanding-read counters throttle issue and drive busy.

Parameters:
ADDR_W, 26, request address width (line address)
DATA_W, 512, data width
BYTEEN_W, DATA_W/8, byte-enable width
TAG_W, 8, requester-side tag width; memory-side tag is TAG_W+1
MAX_OUTS, 8, max outstanding reads per requester (>=1)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
rq_req_valid[i]  in  1  request valid, i in {0,1}
rq_req_rw[i]  in  1  1=write, 0=read
rq_req_byteen[i]  in  BYTEEN_W  byte enables
rq_req_addr[i]  in  ADDR_W  address
rq_req_data[i]  in  DATA_W  write data
rq_req_tag[i]  in  TAG_W  requester tag
rq_req_ready[i]  out  1  request accepted this cycle
rq_rsp_valid[i]  out  1  response valid
rq_rsp_data[i]  out  DATA_W  read data
rq_rsp_tag[i]  out  TAG_W  returned tag, ID bit stripped
rq_rsp_ready[i]  in  1  requester accepts response
mem_req_valid  out  1  to local_mem
mem_req_rw  out  1
mem_req_byteen  out  BYTEEN_W
mem_req_addr  out  ADDR_W
mem_req_data  out  DATA_W
mem_req_tag  out  TAG_W+1  {requester ID, rq tag}
mem_req_ready  in  1
mem_rsp_valid  in  1
mem_rsp_data  in  DATA_W
mem_rsp_tag  in  TAG_W+1
mem_rsp_ready  out  1
busy  out  1  request in flight or any read outstanding
rsp_err  out  1  sticky: response for requester with zero outstanding

Behaviour:
- Reset (async on reset_n low): out register empty (mem_req_valid=0), mem_req_* payload 0, rr pointer favours requester 0, both counters 0, rsp_err=0, busy=0. Combinational outputs under reset with no input activity: rq_req_ready=0, rq_rsp_valid=0, mem_rsp_ready=0.
- Reset mid-operation drops the held request and clears all counters; no flush handshake.
- Eligibility: eligible[i] = rq_req_valid[i] && !(rq_req_rw[i]==0 && cnt[i]==MAX_OUTS). Writes are never throttled.
- Load slot: load = !mem_req_valid || mem_req_ready. Allows back-to-back issue with one request per cycle sustained.
- Grant, combinational: only when load is 1. If one requester is eligible, it wins. If both are eligible, the one not granted last wins. rq_req_ready[i] = grant[i].
- Pointer update: rr pointer updates only on a grant.
- Out register: on grant, latch payload and tag {i, rq_req_tag[i]} and set mem_req_valid. Cleared on mem_req_ready when there is no new grant. Payload is held stable while valid && !ready.
- Latency: request accepted in cycle N appears on mem_req_* in cycle N+1.
- Response routing: id = mem_rsp_tag[TAG_W].
  - rq_rsp_valid[id] = mem_rsp_valid; the other requester's rsp_valid is 0.
  - mem_rsp_ready = rq_rsp_ready[id].
  - Data and lower TAG_W tag bits are broadcast to both requesters.
- Counters, width $clog2(MAX_OUTS+1):
  - +1 on a read grant.
  - -1 on a response handshake (mem_rsp_valid && mem_rsp_ready) for that ID.
  - Simultaneous increment and decrement leaves the counter unchanged.
  - Decrement at 0 saturates at 0 and sets rsp_err (cleared only by reset).
- busy = mem_req_valid || cnt[0]!=0 || cnt[1]!=0.
- Ordering: responses are not reordered; per-requester order is whatever local_mem returns.

Test Plan:
- Single read from req0, addr 0x10, tag 0x05, mem_req_ready=1 -> mem_req_valid in the next cycle with mem_req_tag=0x005, cnt0=1, busy=1. After response with tag 0x005 -> rq_rsp_valid[0]=1, tag 0x05, cnt0=0, busy=0.
- Both requesters valid continuously with reads, ready=1 -> grants alternate 0,1,0,1 starting with 0 after reset; mem_req_tag MSB alternates.
- Backpressure: mem_req_ready=0 for 3 cycles with req1 write addr 0x3 valid -> mem_req payload stable, rq_req_ready=0 for both. On the cycle ready rises, the next grant is issued in that same cycle.
- Throttle: MAX_OUTS=8, req0 issues 8 reads with no responses -> 9th read is held (ready=0) while req1 keeps being granted. Req0 writes are still granted. One response frees req0 on the next cycle.
- Response backpressure: mem_rsp_tag=0x1AA, rq_rsp_ready[1]=0 -> mem_rsp_ready=0 and cnt1 unchanged. Raising ready completes the handshake and decrements cnt1.
- Spurious response with tag 0x0FF while cnt0=0 -> rsp_err=1 and stays set. Asserting reset_n low mid-burst -> mem_req_valid, counters, and rsp_err clear immediately.
